// File: rtl/arbitro_memoria_embarcacoes.sv
// arbitro_memoria_embarcacoes
//
// Arbiter and sequencer for the shared ship-position memory. The memory has
// two player banks and a synchronous read. Three requesters share its single
// port:
//   - posicionador: single writes
//   - colisor:      single reads
//   - VGA:          BURST_LEN-word read bursts at addresses 0..BURST_LEN-1
// This block is the only driver of the memory address, bank-select and
// write-enable lines.
//
// Ports
//   clk, resetGeral           : clock, asynchronous active-low reset
//   pos_req/jogador/addr/wdata: write request (held until pos_gnt)
//   pos_gnt                   : write issued this cycle
//   col_req/jogador/addr      : read request (held until col_gnt)
//   col_gnt                   : read address issued this cycle
//   col_rvalid/col_rdata      : read data
//   vga_req/vga_jogador       : burst request (level), bank sampled at grant
//   vga_gnt                   : first cycle of the burst
//   vga_rvalid/idx/rdata/done : burst data stream, done marks the last word
//   mem_jogador/addr/we/wdata : memory command port
//   mem_rdata                 : memory data, valid one cycle after its address
//
// Optional feature
//   ARBITRO_ANTI_STARVATION_EN: a VGA wait counter lets VGA win the IDLE
//   arbitration over both other requesters once it has waited STARVE_LIMIT
//   cycles. Without the macro, arbitration is pure fixed priority.

module arbitro_memoria_embarcacoes #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 64,
  parameter int BURST_LEN    = 11,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              resetGeral,
  input  logic              pos_req,
  input  logic              pos_jogador,
  input  logic [ADDR_W-1:0] pos_addr,
  input  logic [DATA_W-1:0] pos_wdata,
  output logic              pos_gnt,
  input  logic              col_req,
  input  logic              col_jogador,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_gnt,
  output logic              col_rvalid,
  output logic [DATA_W-1:0] col_rdata,
  input  logic              vga_req,
  input  logic              vga_jogador,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [3:0]        vga_idx,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_done,
  output logic              mem_jogador,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_DATA,
    S_BURST,
    S_BURST_TAIL
  } state_t;

  state_t              state_q, state_d;
  logic                pos_gnt_q, pos_gnt_d;
  logic                col_gnt_q, col_gnt_d;
  logic                col_rvalid_q, col_rvalid_d;
  logic                vga_gnt_q, vga_gnt_d;
  logic                vga_rvalid_q, vga_rvalid_d;
  logic [3:0]          vga_idx_q, vga_idx_d;
  logic                vga_done_q, vga_done_d;
  logic                mem_jogador_q, mem_jogador_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                vga_urgent;

`ifdef ARBITRO_ANTI_STARVATION_EN
  logic [3:0] starve_q, starve_d;

  // Counts cycles VGA is kept waiting outside its own burst; saturates at 15.
  always_comb begin
    starve_d = starve_q;
    if (vga_gnt_q) begin
      starve_d = '0;
    end else if (vga_req && (state_q != S_BURST) && (state_q != S_BURST_TAIL)
                 && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) starve_q <= '0;
    else             starve_q <= starve_d;
  end

  assign vga_urgent = (int'({28'd0, starve_q}) >= STARVE_LIMIT);
`else
  assign vga_urgent = 1'b0;
`endif

  // Every output is a register: the next-state logic also computes what the
  // outputs must show in the state being entered.
  always_comb begin
    state_d       = state_q;
    pos_gnt_d     = 1'b0;
    col_gnt_d     = 1'b0;
    col_rvalid_d  = 1'b0;
    vga_gnt_d     = 1'b0;
    vga_rvalid_d  = 1'b0;
    vga_idx_d     = '0;
    vga_done_d    = 1'b0;
    mem_jogador_d = 1'b0;
    mem_addr_d    = '0;
    mem_we_d      = 1'b0;
    mem_wdata_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (vga_req && vga_urgent) begin
          state_d       = S_BURST;
          vga_gnt_d     = 1'b1;
          mem_jogador_d = vga_jogador;
        end else if (pos_req) begin
          state_d       = S_WR;
          pos_gnt_d     = 1'b1;
          mem_we_d      = 1'b1;
          mem_jogador_d = pos_jogador;
          mem_addr_d    = pos_addr;
          mem_wdata_d   = pos_wdata;
        end else if (col_req) begin
          state_d       = S_RD_ADDR;
          col_gnt_d     = 1'b1;
          mem_jogador_d = col_jogador;
          mem_addr_d    = col_addr;
        end else if (vga_req) begin
          state_d       = S_BURST;
          vga_gnt_d     = 1'b1;
          mem_jogador_d = vga_jogador;
        end
      end
      S_WR: state_d = S_IDLE;
      S_RD_ADDR: begin
        state_d      = S_RD_DATA;
        col_rvalid_d = 1'b1;
      end
      S_RD_DATA: state_d = S_IDLE;
      S_BURST: begin
        // The word addressed now returns next cycle, tagged with this address.
        vga_rvalid_d  = 1'b1;
        vga_idx_d     = mem_addr_q[3:0];
        mem_jogador_d = mem_jogador_q;
        if (mem_addr_q == LAST_ADDR) begin
          state_d    = S_BURST_TAIL;
          vga_done_d = 1'b1;
        end else begin
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      S_BURST_TAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      state_q       <= S_IDLE;
      pos_gnt_q     <= 1'b0;
      col_gnt_q     <= 1'b0;
      col_rvalid_q  <= 1'b0;
      vga_gnt_q     <= 1'b0;
      vga_rvalid_q  <= 1'b0;
      vga_idx_q     <= '0;
      vga_done_q    <= 1'b0;
      mem_jogador_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      pos_gnt_q     <= pos_gnt_d;
      col_gnt_q     <= col_gnt_d;
      col_rvalid_q  <= col_rvalid_d;
      vga_gnt_q     <= vga_gnt_d;
      vga_rvalid_q  <= vga_rvalid_d;
      vga_idx_q     <= vga_idx_d;
      vga_done_q    <= vga_done_d;
      mem_jogador_q <= mem_jogador_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign pos_gnt     = pos_gnt_q;
  assign col_gnt     = col_gnt_q;
  assign col_rvalid  = col_rvalid_q;
  assign vga_gnt     = vga_gnt_q;
  assign vga_rvalid  = vga_rvalid_q;
  assign vga_idx     = vga_idx_q;
  assign vga_done    = vga_done_q;
  assign mem_jogador = mem_jogador_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

  // The memory's own read register is the data register: its word is
  // forwarded in the cycle it is valid and forced to zero otherwise, so
  // nothing leaks out during reset or outside a valid cycle.
  assign col_rdata = col_rvalid_q ? mem_rdata : '0;
  assign vga_rdata = vga_rvalid_q ? mem_rdata : '0;

endmodule

// File: doc/arbitro_memoria_embarcacoes.md
# arbitro_memoria_embarcacoes

Arbiter and sequencer for the shared ship-position memory (two player banks, 32 words × 64 bits each, synchronous read). It shares that single memory port among three requesters: the piece-placement writer (posicionador), the collision/validation reader (colisor), and the VGA compositor, which needs an 11-word burst per frame refresh. It sits between those three blocks and the memory, and is the only driver of the memory address, bank-select and write-enable lines.

## Interface
- `ADDR_W`, 5: memory word address width.
- `DATA_W`, 64: memory word width.
- `BURST_LEN`, 11: words per VGA burst, at addresses 0..BURST_LEN-1.
- `STARVE_LIMIT`, 8: VGA wait-cycle threshold (used only with `ARBITRO_ANTI_STARVATION_EN`).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetGeral`  in  1  asynchronous, active-low reset.
- `pos_req`  in  1  write request; held high until `pos_gnt`.
- `pos_jogador`  in  1  player bank for the write.
- `pos_addr`  in  ADDR_W  write address.
- `pos_wdata`  in  DATA_W  write data.
- `pos_gnt`  out  1  one-cycle pulse: the write is issued this cycle.
- `col_req`  in  1  single-read request; held high until `col_gnt`.
- `col_jogador`  in  1  bank for the read.
- `col_addr`  in  ADDR_W  read address.
- `col_gnt`  out  1  one-cycle pulse: the read address is issued.
- `col_rvalid`  out  1  `col_rdata` is valid this cycle.
- `col_rdata`  out  DATA_W  registered read data.
- `vga_req`  in  1  burst request (level).
- `vga_jogador`  in  1  bank for the burst; sampled at grant.
- `vga_gnt`  out  1  one-cycle pulse: the burst has started.
- `vga_rvalid`  out  1  `vga_rdata`/`vga_idx` are valid this cycle.
- `vga_idx`  out  4  word index 0..BURST_LEN-1.
- `vga_rdata`  out  DATA_W  registered burst data.
- `vga_done`  out  1  pulses together with the last `vga_rvalid`.
- `mem_jogador`  out  1  bank select.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  write enable.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  memory data, valid one cycle after its address is driven.

## Operation
- **Reset values:** while `resetGeral` = 0, every output is 0 and the FSM is in IDLE. Reset is asynchronous.
- **States:**
  - IDLE: arbitrate between pending requests.
  - WR: single write cycle.
  - RD_ADDR / RD_DATA: single read.
  - BURST: issue the VGA burst addresses.
  - BURST_TAIL: deliver the last burst word.
- **IDLE arbitration:** fixed priority posicionador > colisor > VGA. With no request pending, the FSM stays in IDLE.
- **WR:**
  - Drives `mem_we`=1, `mem_addr`=`pos_addr`, `mem_jogador`=`pos_jogador`, `mem_wdata`=`pos_wdata`.
  - `pos_gnt`=1.
  - Next state: IDLE.
- **RD_ADDR:** drives the colisor address and bank, `col_gnt`=1, `mem_we`=0. Next state: RD_DATA.
- **RD_DATA:** registers `mem_rdata` into `col_rdata` and sets `col_rvalid`=1. Next state: IDLE.
- **BURST:**
  - Bank is latched from `vga_jogador` on entry; `vga_gnt` pulses in the first BURST cycle.
  - `mem_addr` steps 0, 1, …, BURST_LEN-1, one per cycle.
  - Each returning word is registered into `vga_rdata`, with `vga_rvalid`=1 and `vga_idx` equal to its address.
  - After address BURST_LEN-1 the FSM goes to BURST_TAIL, which delivers the last word, pulses `vga_done`, and returns to IDLE.
- **Non-preemption:** a burst cannot be interrupted. Requests arriving during a burst wait until it completes.
- **Request drop:** a requester that drops `req` before its grant is simply not served; there is no error.
- **Reset during a transaction:** the transaction is aborted immediately. No `done`/`rvalid` is produced and `mem_we` is forced to 0.
- **`mem_we`** is 1 only in WR, which guarantees no write occurs during a read or a burst.

## Timing
- All outputs are registered.
- Write: request seen in IDLE on cycle T → `pos_gnt` and `mem_we` on T+1 → IDLE on T+2.
- Single read: request seen on cycle T → `col_gnt` on T+1 → `col_rvalid` on T+2 → IDLE on T+3.
- Burst: request seen on cycle T → `vga_gnt` and address 0 on T+1 → word k valid on T+2+k → `vga_done` on T+1+BURST_LEN. The burst occupies the port for BURST_LEN+1 cycles.
- Back-to-back: after any transaction the FSM returns to IDLE and spends one arbitration cycle there before the next grant.
- Simultaneous requests: only the highest-priority requester is granted. The others remain pending and keep their `req` high.

## Configuration
- **`ARBITRO_ANTI_STARVATION_EN` defined:**
  - A 4-bit saturating counter increments every cycle that `vga_req`=1 and the FSM is not in BURST or BURST_TAIL.
  - When the counter is ≥ STARVE_LIMIT, VGA wins the next IDLE arbitration over both other requesters.
  - The counter clears on `vga_gnt` and on reset.
- **Undefined:** pure fixed priority; the counter logic is absent.

## Test plan
- Reset mid-burst at word 5 → all outputs 0 immediately, no `vga_done`; the next `vga_req` starts again from `vga_idx`=0.
- `pos_req` with bank 1, addr 3, data 64'hA5 → `pos_gnt` and `mem_we` on T+1, exactly one write cycle. A subsequent colisor read of bank 1, addr 3 → `col_rvalid` on T+2 with `col_rdata`=64'hA5.
- `vga_req` with memory word k = k → `vga_idx`/`vga_rdata` step 0..10 on consecutive cycles, and `vga_done` coincides with idx 10.
- `pos_req` and `col_req` asserted in the same cycle → `pos_gnt` first, then `col_gnt` two cycles later. `pos_req` raised during a burst → served only after `vga_done`.
- With the macro defined, `col_req` held high continuously while `vga_req` is high → `vga_gnt` occurs within STARVE_LIMIT+4 cycles. With the macro undefined → VGA is never granted.
